// File: rtl/gate_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | gate_arbiter: round-robin arbiter serialising N requesters onto one      |
// | shared AND/NAND unit with a valid/ready response.   Revision: 1.0        |
// +--------------------------------------------------------------------------+
module gate_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] gnt,
    output logic         busy,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [2:0]   rsp_id,
    output logic [1:0]   rsp_c
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]   state_q, state_d;
    logic [2:0]   ptr_q, ptr_d;
    logic [N-1:0] gnt_q, gnt_d;
    logic         op_a_q, op_a_d;
    logic         op_b_q, op_b_d;
    logic [2:0]   id_q, id_d;
    logic [1:0]   rsp_c_q, rsp_c_d;
    logic [2:0]   rsp_id_q, rsp_id_d;

    logic [7:0]   w_req8, w_a8, w_b8;
    logic [3:0]   w_sum;
    logic         w_found;
    logic [2:0]   w_win;
    logic [N-1:0] w_gnt;

    assign w_req8 = 8'(req);
    assign w_a8   = 8'(a);
    assign w_b8   = 8'(b);

    // Round-robin search starting just after the last served requester.
    always_comb begin
        w_found = 1'b0;
        w_win   = 3'd0;
        w_sum   = 4'd0;
        for (int k = 1; k <= N; k++) begin
            w_sum = {1'b0, ptr_q} + 4'(k);
            if (w_sum >= 4'(N)) begin
                w_sum = w_sum - 4'(N);
            end
            if (!w_found && w_req8[w_sum[2:0]]) begin
                w_found = 1'b1;
                w_win   = w_sum[2:0];
            end
        end
    end

    always_comb begin
        w_gnt = '0;
        for (int i = 0; i < N; i++) begin
            w_gnt[i] = (3'(i) == w_win);
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        gnt_d    = '0;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        id_d     = id_q;
        rsp_c_d  = rsp_c_q;
        rsp_id_d = rsp_id_q;
        case (state_q)
            S_IDLE: begin
                if (w_found) begin
                    gnt_d   = w_gnt;
                    op_a_d  = w_a8[w_win];
                    op_b_d  = w_b8[w_win];
                    id_d    = w_win;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                rsp_c_d  = {~(op_a_q & op_b_q), op_a_q & op_b_q};
                rsp_id_d = id_q;
                state_d  = S_RESP;
            end
            S_RESP: begin
                // Pointer moves only on handshake so stalls keep the order.
                if (rsp_ready) begin
                    ptr_d   = rsp_id_q;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            ptr_q    <= 3'(N - 1);
            gnt_q    <= '0;
            op_a_q   <= 1'b0;
            op_b_q   <= 1'b0;
            id_q     <= 3'd0;
            rsp_c_q  <= 2'd0;
            rsp_id_q <= 3'd0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            gnt_q    <= gnt_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            id_q     <= id_d;
            rsp_c_q  <= rsp_c_d;
            rsp_id_q <= rsp_id_d;
        end
    end

    assign gnt       = gnt_q;
    assign busy      = (state_q != S_IDLE);
    assign rsp_valid = (state_q == S_RESP);
    assign rsp_id    = rsp_id_q;
    assign rsp_c     = rsp_c_q;

endmodule
`default_nettype wire

// File: tb/tb_gate_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_gate_arbiter: directed and randomized transactions against a          |
// | transaction-level round-robin reference model.   Revision: 1.0           |
// +--------------------------------------------------------------------------+
module tb_gate_arbiter;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] req = '0;
    logic [N-1:0] a = '0;
    logic [N-1:0] b = '0;
    logic [N-1:0] gnt;
    logic         busy;
    logic         rsp_valid;
    logic         rsp_ready = 1'b0;
    logic [2:0]   rsp_id;
    logic [1:0]   rsp_c;

    int checks = 0;
    int errors = 0;
    int ptr_m  = N - 1;

    gate_arbiter #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .a         (a),
        .b         (b),
        .gnt       (gnt),
        .busy      (busy),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_c     (rsp_c)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: first requesting index after ptr, wrapping modulo N; -1 if none.
    function automatic int rr_pick(input int p, input logic [N-1:0] r);
        for (int k = 1; k <= N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_gnt"}, 32'(gnt), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "_c"}, 32'(rsp_c), 32'd0);
        check({tag, "_id"}, 32'(rsp_id), 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req = '0;
        rsp_ready = 1'b0;
        step();
        check_reset_outputs("reset");
        rst_n = 1'b1;
        ptr_m = N - 1;
    endtask

    // One full transaction from IDLE; inputs change freely once granted.
    task automatic txn(input string tag, input logic [N-1:0] r, input logic [N-1:0] av,
                       input logic [N-1:0] bv, input int stall);
        int w;
        logic [N-1:0] eg;
        logic [1:0] ec;
        req = r;
        a = av;
        b = bv;
        rsp_ready = (stall == 0);
        w = rr_pick(ptr_m, r);
        if (w < 0) begin
            step();
            check({tag, "_idle_gnt"}, 32'(gnt), 32'd0);
            check({tag, "_idle_busy"}, 32'(busy), 32'd0);
            return;
        end
        eg = '0;
        eg[w] = 1'b1;
        ec[0] = av[w] & bv[w];
        ec[1] = ~ec[0];
        step();
        check({tag, "_gnt"}, 32'(gnt), 32'(eg));
        check({tag, "_busy"}, 32'(busy), 32'd1);
        check({tag, "_valid_early"}, 32'(rsp_valid), 32'd0);
        req = N'($urandom);
        a = N'($urandom);
        b = N'($urandom);
        step();
        check({tag, "_valid"}, 32'(rsp_valid), 32'd1);
        check({tag, "_id"}, 32'(rsp_id), 32'(w));
        check({tag, "_c"}, 32'(rsp_c), 32'(ec));
        check({tag, "_gnt_resp"}, 32'(gnt), 32'd0);
        for (int s = 0; s < stall; s++) begin
            req = N'($urandom);
            a = N'($urandom);
            b = N'($urandom);
            step();
            check({tag, "_stall_valid"}, 32'(rsp_valid), 32'd1);
            check({tag, "_stall_id"}, 32'(rsp_id), 32'(w));
            check({tag, "_stall_c"}, 32'(rsp_c), 32'(ec));
            check({tag, "_stall_gnt"}, 32'(gnt), 32'd0);
            check({tag, "_stall_busy"}, 32'(busy), 32'd1);
        end
        rsp_ready = 1'b1;
        req = '0;
        step();
        check({tag, "_done_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "_done_busy"}, 32'(busy), 32'd0);
        ptr_m = w;
    endtask

    initial begin
        do_reset();

        // Single request
        txn("single", 4'b0001, 4'b0001, 4'b0001, 0);

        // Truth table on requester 2
        txn("tt00", 4'b0100, 4'b0000, 4'b0000, 0);
        txn("tt10", 4'b0100, 4'b0100, 4'b0000, 0);
        txn("tt11", 4'b0100, 4'b0100, 4'b0100, 0);
        txn("tt01", 4'b0100, 4'b0000, 4'b0100, 0);

        // Round-robin from reset with all requests held
        do_reset();
        for (int i = 0; i < 5; i++) begin
            txn("rr", 4'b1111, N'($urandom), N'($urandom), 0);
            check("rr_order", 32'(ptr_m), 32'(i % N));
        end

        // Backpressure
        txn("bp", 4'b0010, 4'b0010, 4'b0010, 5);

        // Operand change after grant: a[1]=1,b[1]=1 at grant
        txn("opchg", 4'b0010, 4'b0010, 4'b0010, 2);
        txn("opchg0", 4'b0010, 4'b0000, 4'b0010, 2);

        // Reset during RESP with requests held, handshake at the same edge
        do_reset();
        req = 4'b1111;
        a = N'($urandom);
        b = N'($urandom);
        rsp_ready = 1'b0;
        step();
        check("midrst_gnt0", 32'(gnt), 32'b0001);
        step();
        check("midrst_resp", 32'(rsp_valid), 32'd1);
        rst_n = 1'b0;
        rsp_ready = 1'b1;
        step();
        check_reset_outputs("midrst");
        rst_n = 1'b1;
        rsp_ready = 1'b0;
        step();
        check("midrst_regrant", 32'(gnt), 32'b0001);
        step();
        check("midrst_id", 32'(rsp_id), 32'd0);
        rsp_ready = 1'b1;
        req = '0;
        step();
        check("midrst_done", 32'(busy), 32'd0);
        ptr_m = 0;

        // Randomized transactions, including empty request vectors
        for (int i = 0; i < 60; i++) begin
            txn("rand", N'($urandom), N'($urandom), N'($urandom), int'($urandom_range(0, 3)));
        end

        // A request raised only while busy and dropped before IDLE is never served
        req = '0;
        rsp_ready = 1'b1;
        step();
        check("quiet_gnt", 32'(gnt), 32'd0);
        check("quiet_busy", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
